// File: rtl/sort_share_arbiter.sv
// Shares one sorter between N Avalon-ST requesters: packet-level round-robin in, tag-FIFO routing out.
// Optional length guard (truncate at MAX_PKT_LEN and drop the tail) enabled by SORT_SHARE_LEN_GUARD_EN.
module sort_share_arbiter #(
    parameter int N           = 4,
    parameter int DWIDTH      = 8,
    parameter int MAX_PKT_LEN = 16,
    parameter int TAG_DEPTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [N*DWIDTH-1:0]   req_data_i,
    input  logic [N-1:0]          req_startofpacket_i,
    input  logic [N-1:0]          req_endofpacket_i,
    input  logic [N-1:0]          req_valid_i,
    output logic [N-1:0]          req_ready_o,
    output logic [DWIDTH-1:0]     sort_snk_data_o,
    output logic                  sort_snk_startofpacket_o,
    output logic                  sort_snk_endofpacket_o,
    output logic                  sort_snk_valid_o,
    input  logic                  sort_snk_ready_i,
    input  logic [DWIDTH-1:0]     sort_src_data_i,
    input  logic                  sort_src_startofpacket_i,
    input  logic                  sort_src_endofpacket_i,
    input  logic                  sort_src_valid_i,
    output logic                  sort_src_ready_o,
    output logic [N*DWIDTH-1:0]   rsp_data_o,
    output logic [N-1:0]          rsp_startofpacket_o,
    output logic [N-1:0]          rsp_endofpacket_o,
    output logic [N-1:0]          rsp_valid_o,
    input  logic [N-1:0]          rsp_ready_i
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [GW-1:0] LAST_REQ = GW'(N - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(TAG_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   rr_reg, grant_reg, pick;
    logic            pick_found;
    logic [GW-1:0]   tag_mem [TAG_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]     count_reg;
    logic            fifo_full, fifo_empty, push, pop;
    logic [GW-1:0]   head;

    assign fifo_full  = (count_reg == FULL_CNT);
    assign fifo_empty = (count_reg == '0);
    assign head       = tag_mem[rd_ptr_reg];

    // First requester strictly after the rr pointer wins; the pointer itself is checked last.
    always_comb begin
        int idx;
        idx        = 0;
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(rr_reg) + i) % N;
            if (!pick_found && req_valid_i[idx] && req_startofpacket_i[idx]) begin
                pick_found = 1'b1;
                pick       = idx[GW-1:0];
            end
        end
    end

`ifdef SORT_SHARE_LEN_GUARD_EN
    localparam int CW = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(MAX_PKT_LEN - 1);
    logic [CW-1:0] word_cnt_reg;
    logic          at_limit;
    assign at_limit = (word_cnt_reg == LAST_WORD);
`endif

    always_comb begin
        state_next               = state_reg;
        push                     = 1'b0;
        req_ready_o              = '0;
        sort_snk_data_o          = req_data_i[grant_reg*DWIDTH +: DWIDTH];
        sort_snk_startofpacket_o = 1'b0;
        sort_snk_endofpacket_o   = 1'b0;
        sort_snk_valid_o         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_found && !fifo_full) begin
                    push       = 1'b1;
                    state_next = FWD;
                end
            end
            FWD: begin
                sort_snk_valid_o         = req_valid_i[grant_reg];
                sort_snk_startofpacket_o = req_startofpacket_i[grant_reg];
                sort_snk_endofpacket_o   = req_endofpacket_i[grant_reg];
                req_ready_o[grant_reg]   = sort_snk_ready_i;
`ifdef SORT_SHARE_LEN_GUARD_EN
                if (at_limit)
                    sort_snk_endofpacket_o = 1'b1;
                if (req_valid_i[grant_reg] && sort_snk_ready_i) begin
                    if (req_endofpacket_i[grant_reg])
                        state_next = IDLE;
                    else if (at_limit)
                        state_next = DROP;
                end
`else
                if (req_valid_i[grant_reg] && sort_snk_ready_i && req_endofpacket_i[grant_reg])
                    state_next = IDLE;
`endif
            end
`ifdef SORT_SHARE_LEN_GUARD_EN
            DROP: begin
                // Swallow the oversize tail so the requester can finish its packet.
                req_ready_o[grant_reg] = 1'b1;
                if (req_valid_i[grant_reg] && req_endofpacket_i[grant_reg])
                    state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_reg  <= IDLE;
            rr_reg     <= LAST_REQ;
            grant_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                grant_reg  <= pick;
                rr_reg     <= pick;
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (push && !pop)
                count_reg <= count_reg + CNT_ONE;
            else if (pop && !push)
                count_reg <= count_reg - CNT_ONE;
        end
    end

`ifdef SORT_SHARE_LEN_GUARD_EN
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i)
            word_cnt_reg <= '0;
        else if (push)
            word_cnt_reg <= '0;
        else if (state_reg == FWD && req_valid_i[grant_reg] && sort_snk_ready_i)
            word_cnt_reg <= word_cnt_reg + 1'b1;
    end
`endif

    // Tag storage needs no reset: entries are only read while count_reg covers them.
    always_ff @(posedge clk_i) begin
        if (push)
            tag_mem[wr_ptr_reg] <= pick;
    end

    assign rsp_data_o = {N{sort_src_data_i}};
    assign pop        = !fifo_empty && sort_src_valid_i && sort_src_ready_o && sort_src_endofpacket_i;

    always_comb begin
        rsp_valid_o         = '0;
        rsp_startofpacket_o = '0;
        rsp_endofpacket_o   = '0;
        sort_src_ready_o    = 1'b0;
        if (!fifo_empty) begin
            rsp_valid_o[head]         = sort_src_valid_i;
            rsp_startofpacket_o[head] = sort_src_startofpacket_i;
            rsp_endofpacket_o[head]   = sort_src_endofpacket_i;
            sort_src_ready_o          = rsp_ready_i[head];
        end
    end
endmodule

// File: tb/tb_sort_share_arbiter.sv
// Directed bench for sort_share_arbiter; the bench itself plays the sorter on both sides.
// Expected lengths adapt when SORT_SHARE_LEN_GUARD_EN is defined.
module tb_sort_share_arbiter;
    localparam int N = 4;
    localparam int DW = 8;

    logic            clk_i = 1'b0;
    logic            srst_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_startofpacket_i, req_endofpacket_i, req_valid_i, req_ready_o;
    logic [DW-1:0]   sort_snk_data_o;
    logic            sort_snk_startofpacket_o, sort_snk_endofpacket_o, sort_snk_valid_o;
    logic            sort_snk_ready_i;
    logic [DW-1:0]   sort_src_data_i;
    logic            sort_src_startofpacket_i, sort_src_endofpacket_i, sort_src_valid_i;
    logic            sort_src_ready_o;
    logic [N*DW-1:0] rsp_data_o;
    logic [N-1:0]    rsp_startofpacket_o, rsp_endofpacket_o, rsp_valid_o, rsp_ready_i;

    logic          v_a [N];
    logic          s_a [N];
    logic          e_a [N];
    logic [DW-1:0] d_a [N];
    logic [DW-1:0] pw [N][32];
    logic [DW-1:0] rw [32];
    logic [9:0]    snk_q [$];
    int vectors = 0;
    int miscompares = 0;

`ifdef SORT_SHARE_LEN_GUARD_EN
    localparam int LONG_EXP = 16;
    localparam logic EOP16_EXP = 1'b1;
`else
    localparam int LONG_EXP = 20;
    localparam logic EOP16_EXP = 1'b0;
`endif

    sort_share_arbiter #(.N(N), .DWIDTH(DW), .MAX_PKT_LEN(16), .TAG_DEPTH(4)) dut (
        .clk_i(clk_i), .srst_i(srst_i),
        .req_data_i(req_data_i), .req_startofpacket_i(req_startofpacket_i),
        .req_endofpacket_i(req_endofpacket_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .sort_snk_data_o(sort_snk_data_o), .sort_snk_startofpacket_o(sort_snk_startofpacket_o),
        .sort_snk_endofpacket_o(sort_snk_endofpacket_o), .sort_snk_valid_o(sort_snk_valid_o),
        .sort_snk_ready_i(sort_snk_ready_i),
        .sort_src_data_i(sort_src_data_i), .sort_src_startofpacket_i(sort_src_startofpacket_i),
        .sort_src_endofpacket_i(sort_src_endofpacket_i), .sort_src_valid_i(sort_src_valid_i),
        .sort_src_ready_o(sort_src_ready_o),
        .rsp_data_o(rsp_data_o), .rsp_startofpacket_o(rsp_startofpacket_o),
        .rsp_endofpacket_o(rsp_endofpacket_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]         = v_a[k];
            req_startofpacket_i[k] = s_a[k];
            req_endofpacket_i[k]   = e_a[k];
            req_data_i[k*DW +: DW] = d_a[k];
        end
    end

    always @(posedge clk_i)
        if (!srst_i && sort_snk_valid_o && sort_snk_ready_i)
            snk_q.push_back({sort_snk_startofpacket_o, sort_snk_endofpacket_o, sort_snk_data_o});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt(input int k, input int len);
        int j = 0;
        int t = 0;
        logic r;
        v_a[k] = 1'b1; s_a[k] = 1'b1; e_a[k] = (len == 1); d_a[k] = pw[k][0];
        while (j < len && t < 300) begin
            @(negedge clk_i);
            r = req_ready_o[k];
            @(posedge clk_i); #1;
            t++;
            if (r) begin
                j++;
                if (j < len) begin
                    s_a[k] = 1'b0; e_a[k] = (j == len - 1); d_a[k] = pw[k][j];
                end else begin
                    v_a[k] = 1'b0; s_a[k] = 1'b0; e_a[k] = 1'b0;
                end
            end
        end
        v_a[k] = 1'b0;
        chk($sformatf("send_done_req%0d", k), j, len);
    endtask

    task automatic recv_pkt(input int lane, input int len, input bit tog);
        int j = 0;
        int t = 0;
        logic r;
        rsp_ready_i = '1;
        sort_src_valid_i = 1'b1; sort_src_startofpacket_i = 1'b1;
        sort_src_endofpacket_i = (len == 1); sort_src_data_i = rw[0];
        while (j < len && t < 300) begin
            if (tog) rsp_ready_i[lane] = t[0];
            @(negedge clk_i);
            chk("rsp_valid_lane", rsp_valid_o, 32'(1 << lane));
            chk("src_ready_follow", sort_src_ready_o, rsp_ready_i[lane]);
            if (sort_src_ready_o) begin
                chk("rsp_data", rsp_data_o[lane*DW +: DW], rw[j]);
                chk("rsp_sop", rsp_startofpacket_o, 32'((j == 0) ? (1 << lane) : 0));
                chk("rsp_eop", rsp_endofpacket_o, 32'((j == len - 1) ? (1 << lane) : 0));
            end
            r = sort_src_ready_o;
            @(posedge clk_i); #1;
            t++;
            if (r) begin
                j++;
                sort_src_startofpacket_i = 1'b0;
                sort_src_endofpacket_i = (j == len - 1);
                sort_src_data_i = rw[j];
            end
        end
        sort_src_valid_i = 1'b0; sort_src_endofpacket_i = 1'b0;
        rsp_ready_i = '1;
        chk($sformatf("recv_done_lane%0d", lane), j, len);
    endtask

    task automatic chk_snk(input int idx, input logic sop, input logic eop, input logic [7:0] d);
        chk($sformatf("snk_word%0d", idx), snk_q[idx], {sop, eop, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        for (int k = 0; k < N; k++) begin
            v_a[k] = 0; s_a[k] = 0; e_a[k] = 0; d_a[k] = 0;
        end
        srst_i = 1'b1; sort_snk_ready_i = 1'b1; rsp_ready_i = '1;
        sort_src_valid_i = 1'b0; sort_src_startofpacket_i = 1'b0;
        sort_src_endofpacket_i = 1'b0; sort_src_data_i = '0;

        // Reset: outputs held low even with live requests and sorter output
        v_a[0] = 1; s_a[0] = 1; sort_src_valid_i = 1;
        #2;
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_snk_valid", sort_snk_valid_o, 0);
        chk("rst_src_ready", sort_src_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        v_a[0] = 0; s_a[0] = 0; sort_src_valid_i = 0;
        @(posedge clk_i); #1; srst_i = 1'b0;

        // Single 4-word packet from requester 0
        pw[0][0] = 9; pw[0][1] = 3; pw[0][2] = 7; pw[0][3] = 1;
        snk_q.delete();
        send_pkt(0, 4);
        chk("t1_snk_count", snk_q.size(), 4);
        chk_snk(0, 1, 0, 9); chk_snk(1, 0, 0, 3); chk_snk(2, 0, 0, 7); chk_snk(3, 0, 1, 1);
        rw[0] = 1; rw[1] = 3; rw[2] = 7; rw[3] = 9;
        recv_pkt(0, 4, 0);
        sort_src_valid_i = 1;
        #1;
        chk("t1_empty_src_ready", sort_src_ready_o, 0);
        chk("t1_empty_rsp_valid", rsp_valid_o, 0);
        sort_src_valid_i = 0;

        // Simultaneous requests after reset: grant order 0,1,2,3
        srst_i = 1; @(posedge clk_i); #1; srst_i = 0;
        for (int k = 0; k < N; k++) begin
            pw[k][0] = 8'(8'h10 * k + 2); pw[k][1] = 8'(8'h10 * k + 1);
        end
        snk_q.delete();
        fork
            send_pkt(0, 2); send_pkt(1, 2); send_pkt(2, 2); send_pkt(3, 2);
        join
        chk("t2_snk_count", snk_q.size(), 8);
        for (int k = 0; k < N; k++) begin
            chk_snk(2*k, 1, 0, 8'(8'h10 * k + 2));
            chk_snk(2*k + 1, 0, 1, 8'(8'h10 * k + 1));
        end
        for (int k = 0; k < N; k++) begin
            rw[0] = 8'(8'h10 * k + 1); rw[1] = 8'(8'h10 * k + 2);
            recv_pkt(k, 2, 0);
        end

        // Tag FIFO full: fifth packet held until one response completes
        rsp_ready_i = '0;
        for (int k = 0; k < N; k++) begin
            pw[k][0] = 8'(8'h20 + k);
            send_pkt(k, 1);
        end
        v_a[0] = 1; s_a[0] = 1; e_a[0] = 1; d_a[0] = 8'h55;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("t3_full_hold_ready", req_ready_o, 0);
            chk("t3_full_snk_valid", sort_snk_valid_o, 0);
        end
        @(posedge clk_i); #1;
        sort_src_valid_i = 1; sort_src_startofpacket_i = 1; sort_src_endofpacket_i = 1;
        sort_src_data_i = 8'h20; rsp_ready_i = 4'b0001;
        @(negedge clk_i);
        chk("t3_pop_src_ready", sort_src_ready_o, 1);
        chk("t3_pop_rsp_valid", rsp_valid_o, 4'b0001);
        @(posedge clk_i); #1;
        sort_src_valid_i = 0; sort_src_startofpacket_i = 0; sort_src_endofpacket_i = 0;
        rsp_ready_i = '0;
        @(negedge clk_i);
        chk("t3_bubble_ready", req_ready_o, 0);
        @(negedge clk_i);
        chk("t3_fifth_grant", req_ready_o, 4'b0001);
        chk("t3_fifth_data", sort_snk_data_o, 8'h55);
        @(posedge clk_i); #1;
        v_a[0] = 0; s_a[0] = 0; e_a[0] = 0;
        for (int k = 1; k <= N; k++) begin
            rw[0] = (k == N) ? 8'h55 : 8'(8'h20 + k);
            recv_pkt(k % N, 1, 0);
        end

        // Toggling ready on the routed lane only
        pw[1][0] = 4; pw[1][1] = 6; pw[1][2] = 2;
        snk_q.delete();
        send_pkt(1, 3);
        chk("t4_snk_count", snk_q.size(), 3);
        chk_snk(0, 1, 0, 4); chk_snk(2, 0, 1, 2);
        rw[0] = 2; rw[1] = 4; rw[2] = 6;
        recv_pkt(1, 3, 1);

        // Reset in the middle of a 10-word packet
        snk_q.delete();
        v_a[3] = 1; s_a[3] = 1; d_a[3] = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_i); #1;
            acc = snk_q.size();
            if (acc == 3) break;
            d_a[3] = 8'(acc); s_a[3] = (acc == 0);
        end
        chk("t5_words_before_rst", snk_q.size(), 3);
        sort_src_valid_i = 1; rsp_ready_i = '1;
        #1;
        chk("t5_pre_rst_rsp_valid", rsp_valid_o, 4'b1000);
        srst_i = 1; #1;
        chk("t5_rst_req_ready", req_ready_o, 0);
        chk("t5_rst_snk_valid", sort_snk_valid_o, 0);
        chk("t5_rst_src_ready", sort_src_ready_o, 0);
        chk("t5_rst_rsp_valid", rsp_valid_o, 0);
        @(posedge clk_i); #1;
        srst_i = 0; v_a[3] = 0; s_a[3] = 0;
        @(negedge clk_i);
        chk("t5_post_rst_src_ready", sort_src_ready_o, 0);
        chk("t5_post_rst_rsp_valid", rsp_valid_o, 0);
        sort_src_valid_i = 0;
        pw[2][0] = 5; pw[2][1] = 2; pw[2][2] = 8;
        snk_q.delete();
        send_pkt(2, 3);
        chk("t5_snk_count", snk_q.size(), 3);
        chk_snk(0, 1, 0, 5); chk_snk(1, 0, 0, 2); chk_snk(2, 0, 1, 8);
        rw[0] = 2; rw[1] = 5; rw[2] = 8;
        recv_pkt(2, 3, 0);

        // 20-word packet against MAX_PKT_LEN=16
        for (int i = 0; i < 20; i++) pw[0][i] = 8'(i + 1);
        snk_q.delete();
        send_pkt(0, 20);
        chk("t6_snk_count", snk_q.size(), LONG_EXP);
        chk_snk(15, 0, EOP16_EXP, 16);
        chk_snk(LONG_EXP - 1, 0, 1, 8'(LONG_EXP));
        rw[0] = 1; rw[1] = 2;
        recv_pkt(0, 2, 0);
        pw[1][0] = 8'h33; pw[1][1] = 8'h11;
        snk_q.delete();
        send_pkt(1, 2);
        chk("t6_next_count", snk_q.size(), 2);
        chk_snk(0, 1, 0, 8'h33); chk_snk(1, 0, 1, 8'h11);
        rw[0] = 8'h11; rw[1] = 8'h33;
        recv_pkt(1, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sort_share_arbiter.md
Name: sort_share_arbiter

Overview:
- Shares one main_sort instance between N packet requesters over Avalon-ST.
- Input side: round-robin arbitration at packet granularity; the granted requester's packet is forwarded to the sorter sink.
- Grant index is pushed into a tag FIFO. Output side: each sorted packet from the sorter source is routed back to the requester at the FIFO head.
- Sits between N client streams and main_sort (DWIDTH, MAX_PKT_LEN passed through).

Parameters:
- N, 4, number of requesters (2..8).
- DWIDTH, 8, data word width.
- MAX_PKT_LEN, 16, max words per packet; must match the sorter.
- TAG_DEPTH, 4, tag FIFO depth (power of 2) = max packets in flight inside the sorter.

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  reset; asynchronous, active-high.
- req_data_i  in  N*DWIDTH  requester data; slice k = requester k.
- req_startofpacket_i  in  N  per-requester SOP.
- req_endofpacket_i  in  N  per-requester EOP.
- req_valid_i  in  N  per-requester valid.
- req_ready_o  out  N  per-requester ready.
- sort_snk_data_o  out  DWIDTH  to sorter sink.
- sort_snk_startofpacket_o  out  1  to sorter sink.
- sort_snk_endofpacket_o  out  1  to sorter sink.
- sort_snk_valid_o  out  1  to sorter sink.
- sort_snk_ready_i  in  1  from sorter sink.
- sort_src_data_i  in  DWIDTH  from sorter source.
- sort_src_startofpacket_i  in  1  from sorter source.
- sort_src_endofpacket_i  in  1  from sorter source.
- sort_src_valid_i  in  1  from sorter source.
- sort_src_ready_o  out  1  to sorter source.
- rsp_data_o  out  N*DWIDTH  every slice = sort_src_data_i.
- rsp_startofpacket_o  out  N  SOP; only the routed lane is nonzero.
- rsp_endofpacket_o  out  N  EOP; only the routed lane is nonzero.
- rsp_valid_o  out  N  valid; only the routed lane is nonzero.
- rsp_ready_i  in  N  per-requester ready.

Behaviour:
- Reset:
  - Arbiter state IDLE; rr pointer = N-1, so requester 0 wins first.
  - Tag FIFO emptied; all in-flight packets abandoned.
  - While srst_i is high and until the next clk_i edge: req_ready_o=0, sort_snk_valid_o=0, sort_src_ready_o=0, rsp_valid_o=0.
- Arbiter FSM:
  - IDLE:
    - Request k = req_valid_i[k] & req_startofpacket_i[k].
    - Valid without SOP is not a request and is held (ready 0).
    - If any request and tag FIFO not full, pick the first requester after rr pointer in cyclic order.
    - Register grant g, set rr=g, push g to tag FIFO, go to FWD.
    - In IDLE all req_ready_o=0 and sort_snk_valid_o=0. This gives a 1-cycle bubble per packet.
  - FWD, combinational pass-through:
    - sort_snk_* = requester g's signals.
    - req_ready_o[g] = sort_snk_ready_i; other req_ready_o bits = 0.
    - On handshake with EOP, return to IDLE next cycle.
- Return path:
  - Tag FIFO empty: sort_src_ready_o=0, rsp_valid_o=0.
  - Tag FIFO not empty, head h:
    - rsp_valid_o[h]=sort_src_valid_i; SOP/EOP routed to lane h only.
    - sort_src_ready_o = rsp_ready_i[h].
    - Pop on sort_src handshake with EOP.
- Push and pop may occur in the same cycle. Push is only ever attempted when not full, so count is then unchanged. Pointers wrap mod TAG_DEPTH.
- Tag FIFO full: no grant. Requesters stall until a pop.
- A requester may be granted back-to-back only if no other requester is requesting (fairness).
- Requester releasing valid mid-packet: grant is held; no timeout.

Optional Feature:
- Macro SORT_SHARE_LEN_GUARD_EN.
- Defined:
  - Counts accepted words in FWD.
  - On the MAX_PKT_LEN-th word without EOP, sort_snk_endofpacket_o is forced to 1.
  - The remaining words of that requester, through its EOP, are accepted (req_ready_o[g]=1) and dropped (sort_snk_valid_o=0).
  - Then return to IDLE.
- Undefined: no counting; the packet passes unmodified.

Test Plan:
- Reset, then requester 0 sends a 4-word packet [9,3,7,1]: sort_snk sees 4 words with SOP on the first and EOP on the last. The sorted response appears only on lane 0; rsp_valid_o[1..3] stay 0.
- Requesters 0..3 assert SOP in the same cycle, 2 words each: grant order 0,1,2,3. Responses return in the same order, each on its own lane.
- TAG_DEPTH=4, rsp_ready_i=0, 5 packets queued: 4 granted, 5th held with req_ready_o=0. Raising rsp_ready_i[0] for one packet EOP frees a tag, and the 5th is granted the next IDLE cycle.
- rsp_ready_i[h] toggles 50% while other rsp_ready_i bits = 1: sort_src_ready_o follows only lane h, with no data loss.
- srst_i asserted mid-packet (word 3 of 10): all outputs drop to 0 immediately. Tag FIFO is empty afterwards, and a fresh 3-word packet from requester 2 completes correctly.
- With SORT_SHARE_LEN_GUARD_EN, send a 20-word packet with MAX_PKT_LEN=16: sort_snk carries 16 words, EOP on the 16th. 4 words are dropped with req_ready_o=1; the next packet is arbitrated normally.
